// File: rtl/new_ram4.sv
// Mixed-width simple dual-port RAM: 2-bit write port A, 4-bit registered read port B.
// Each B word packs two adjacent A symbols, with the odd A address in the upper half.
module new_ram4 #(
    parameter int unsigned A_ADDR_W = 12,
    parameter int unsigned A_DATA_W = 2,
    parameter int unsigned B_ADDR_W = 11,
    parameter int unsigned B_DATA_W = 4
) (
    input  logic                ClockA,
    input  logic                ResetA,
    input  logic                ClockEnA,
    input  logic                WrA,
    input  logic [A_ADDR_W-1:0] AddressA,
    input  logic [A_DATA_W-1:0] DataInA,
    input  logic                ClockEnB,
    input  logic [B_ADDR_W-1:0] AddressB,
    output logic [B_DATA_W-1:0] QB
);

    localparam int unsigned BDepth = 2 ** B_ADDR_W;

    // Stored at the wide port's geometry; A writes land in one half of a word.
    logic [B_DATA_W-1:0] mem [BDepth] = '{default: '0};

    logic                wr_en;
    logic [B_ADDR_W-1:0] wr_word;
    logic                wr_upper;
    logic [B_DATA_W-1:0] qb_d;
    logic [B_DATA_W-1:0] qb_q = '0;

    always_comb begin
        wr_en    = ~ResetA & ClockEnA & WrA;
        wr_word  = AddressA[A_ADDR_W-1:1];
        wr_upper = AddressA[0];
    end

    always_ff @(posedge ClockA) begin
        if (wr_en) begin
            if (wr_upper) begin
                mem[wr_word][B_DATA_W-1 -: A_DATA_W] <= DataInA;
            end else begin
                mem[wr_word][A_DATA_W-1:0] <= DataInA;
            end
        end
    end

    // Read samples the array before this edge's write lands: read-before-write.
    always_comb begin
        qb_d = qb_q;
        if (ResetA) begin
            qb_d = '0;
        end else if (ClockEnB) begin
            qb_d = mem[AddressB];
        end
    end

    always_ff @(posedge ClockA) begin
        qb_q <= qb_d;
    end

    assign QB = qb_q;

endmodule

// File: tb/tb_new_ram4.sv
// Self-checking bench for new_ram4: directed scenarios plus randomized traffic
// compared against a flat symbol-array reference model.
module tb_new_ram4;

    logic        ClockA = 1'b0;
    logic        ResetA = 1'b1;
    logic        ClockEnA = 1'b0;
    logic        WrA = 1'b0;
    logic [11:0] AddressA = '0;
    logic [1:0]  DataInA = '0;
    logic        ClockEnB = 1'b0;
    logic [10:0] AddressB = '0;
    logic [3:0]  QB;

    int checks = 0;
    int failures = 0;

    // Reference: 4096 two-bit symbols plus the expected registered output.
    logic [1:0] model_mem [4096];
    logic [3:0] model_qb = '0;

    new_ram4 dut (
        .ClockA   (ClockA),
        .ResetA   (ResetA),
        .ClockEnA (ClockEnA),
        .WrA      (WrA),
        .AddressA (AddressA),
        .DataInA  (DataInA),
        .ClockEnB (ClockEnB),
        .AddressB (AddressB),
        .QB       (QB)
    );

    always #5 ClockA = ~ClockA;

    // Advance one edge and update the model from the inputs present at that edge.
    task automatic cycle();
        logic [3:0] nq;
        logic       wen;
        int         wi;
        logic [1:0] wd;
        nq = model_qb;
        if (ResetA) begin
            nq = 4'b0000;
        end else if (ClockEnB) begin
            nq = {model_mem[int'(AddressB) * 2 + 1], model_mem[int'(AddressB) * 2]};
        end
        wen = !ResetA && ClockEnA && WrA;
        wi  = int'(AddressA);
        wd  = DataInA;
        @(posedge ClockA);
        #1;
        model_qb = nq;
        if (wen) model_mem[wi] = wd;
    endtask

    task automatic test_reset();
        ResetA   = 1'b1;
        ClockEnB = 1'b1;
        AddressB = 11'h000;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (QB !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d QB=%b expected=0000", i, QB);
            end
        end
        ResetA = 1'b0;
        cycle();
        checks++;
        if (QB !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release QB=%b expected=0000", QB);
        end
    endtask

    task automatic test_mixed_width();
        ClockEnA = 1'b1;
        WrA      = 1'b1;
        AddressA = 12'h000;
        DataInA  = 2'b00;
        cycle();
        AddressA = 12'hFFF;
        DataInA  = 2'b10;
        cycle();
        WrA      = 1'b0;
        AddressA = 12'hFFD;
        DataInA  = 2'b11;
        ClockEnB = 1'b1;
        AddressB = 11'h7FF;
        cycle();
        checks++;
        if (QB !== 4'b1000) begin
            failures++;
            $display("FAIL mixed_top_word QB=%b expected=1000", QB);
        end
        AddressB = 11'h7FE;
        cycle();
        checks++;
        if (QB !== 4'b0000) begin
            failures++;
            $display("FAIL wr_disabled_ffd QB=%b expected=0000", QB);
        end
    endtask

    task automatic test_symbol_order();
        ClockEnA = 1'b1;
        WrA      = 1'b1;
        AddressA = 12'h004;
        DataInA  = 2'b01;
        cycle();
        AddressA = 12'h005;
        DataInA  = 2'b11;
        cycle();
        WrA      = 1'b0;
        ClockEnB = 1'b1;
        AddressB = 11'h002;
        cycle();
        checks++;
        if (QB !== 4'b1101) begin
            failures++;
            $display("FAIL symbol_order QB=%b expected=1101", QB);
        end
    endtask

    task automatic test_enables();
        ClockEnA = 1'b0;
        WrA      = 1'b1;
        AddressA = 12'h010;
        DataInA  = 2'b11;
        ClockEnB = 1'b0;
        cycle();
        ClockEnA = 1'b1;
        WrA      = 1'b0;
        ClockEnB = 1'b1;
        AddressB = 11'h008;
        cycle();
        checks++;
        if (QB !== 4'b0000) begin
            failures++;
            $display("FAIL cea_gates_write QB=%b expected=0000", QB);
        end
        AddressB = 11'h002;
        cycle();
        checks++;
        if (QB !== 4'b1101) begin
            failures++;
            $display("FAIL reload_word2 QB=%b expected=1101", QB);
        end
        ClockEnB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            AddressB = 11'h7FF - 11'(i);
            cycle();
            checks++;
            if (QB !== 4'b1101) begin
                failures++;
                $display("FAIL ceb_hold cycle=%0d QB=%b expected=1101", i, QB);
            end
        end
    endtask

    task automatic test_collision();
        ClockEnA = 1'b1;
        WrA      = 1'b1;
        AddressA = 12'hFFE;
        DataInA  = 2'b01;
        ClockEnB = 1'b1;
        AddressB = 11'h7FF;
        cycle();
        checks++;
        if (QB !== 4'b1000) begin
            failures++;
            $display("FAIL collision_old QB=%b expected=1000", QB);
        end
        WrA = 1'b0;
        cycle();
        checks++;
        if (QB !== 4'b1001) begin
            failures++;
            $display("FAIL collision_new QB=%b expected=1001", QB);
        end
    endtask

    task automatic test_reset_midstream();
        ResetA   = 1'b1;
        ClockEnA = 1'b1;
        WrA      = 1'b1;
        AddressA = 12'h020;
        DataInA  = 2'b11;
        ClockEnB = 1'b1;
        AddressB = 11'h7FF;
        cycle();
        checks++;
        if (QB !== 4'b0000) begin
            failures++;
            $display("FAIL reset_read_zero QB=%b expected=0000", QB);
        end
        ResetA   = 1'b0;
        WrA      = 1'b0;
        AddressB = 11'h010;
        cycle();
        checks++;
        if (QB !== 4'b0000) begin
            failures++;
            $display("FAIL reset_drops_write QB=%b expected=0000", QB);
        end
        AddressB = 11'h7FF;
        cycle();
        checks++;
        if (QB !== 4'b1001) begin
            failures++;
            $display("FAIL post_reset_read QB=%b expected=1001", QB);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            ResetA   = ($urandom_range(0, 39) == 0);
            ClockEnA = ($urandom_range(0, 3) != 0);
            WrA      = ($urandom_range(0, 2) != 0);
            ClockEnB = ($urandom_range(0, 3) != 0);
            DataInA  = 2'($urandom);
            // Mostly a small window so writes and reads collide often.
            if ($urandom_range(0, 4) == 0) begin
                AddressA = 12'($urandom);
                AddressB = 11'($urandom);
            end else begin
                AddressA = 12'($urandom_range(0, 31));
                AddressB = 11'($urandom_range(0, 15));
            end
            cycle();
            checks++;
            if (QB !== model_qb) begin
                failures++;
                errs++;
                if (errs <= 10) begin
                    $display("FAIL random cycle=%0d QB=%b expected=%b", i, QB, model_qb);
                end
            end
        end
        ResetA = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model_mem[i] = 2'b00;
        #2;
        test_reset();
        test_mixed_width();
        test_symbol_order();
        test_enables();
        test_collision();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
